usb_ep_in_arbiter: RTL and testbench

Sequential arbiter granting the shared USB IN packet path to one of N_EP_IN IN endpoints at a time. It holds the grant for a whole packet transaction until the IN protocol engine reports completion. A watchdog frees the path if completion never arrives. Sits between the IN endpoint FIFOs and the IN protocol engine; it is the transmit-side counterpart of the OUT endpoint arbiter.

---
 rtl/usb_ep_in_arbiter.sv | 179 +++++++++++++++++
 tb/tb_usb_ep_in_arbiter.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_ep_in_arbiter.sv
// Grants the shared USB IN packet path to one IN endpoint per transaction, with a hold watchdog.
// Optional build macro USB_EP_IN_ARB_ROUNDROBIN_EN selects round-robin instead of fixed lowest-index priority.
module usb_ep_in_arbiter #(
    parameter int N_EP_IN        = 1,
    parameter int TIMEOUT_CYCLES = 1023,
    localparam int IDX_W         = (N_EP_IN > 1) ? $clog2(N_EP_IN) : 1
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [N_EP_IN-1:0] i_inEp_req,
    output logic [N_EP_IN-1:0] o_inEp_grant,
    output logic               o_inEp_granted,
    output logic [IDX_W-1:0]   o_inEp_idx,
    input  logic               i_txn_done,
    output logic               o_timeout
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);
    localparam logic             WDOG_EN  = (TIMEOUT_CYCLES != 0);

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_GRANTED = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [N_EP_IN-1:0] grant_q, grant_d;
    logic               granted_q, granted_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               timeout_q, timeout_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [IDX_W-1:0]   pick_idx_s;
    logic               owner_req_s;
    logic               expiry_s;
    logic [CNT_W-1:0]   cnt_inc_s;

    function automatic logic [IDX_W-1:0] lowest_set(input logic [N_EP_IN-1:0] vec);
        logic [IDX_W-1:0] res;
        res = {IDX_W{1'b0}};
        for (int i = N_EP_IN - 1; i >= 0; i--) begin
            if (vec[i]) begin
                res = IDX_W'(i);
            end
        end
        return res;
    endfunction

    function automatic logic [N_EP_IN-1:0] to_onehot(input logic [IDX_W-1:0] idx);
        logic [N_EP_IN-1:0] res;
        res = {N_EP_IN{1'b0}};
        for (int i = 0; i < N_EP_IN; i++) begin
            res[i] = (IDX_W'(i) == idx);
        end
        return res;
    endfunction

`ifdef USB_EP_IN_ARB_ROUNDROBIN_EN
    logic [IDX_W-1:0]   last_q, last_d;
    logic [N_EP_IN-1:0] above_mask_s;
    logic [N_EP_IN-1:0] req_above_s;

    // Winner: first requester above the last winner, else wrap to the lowest requester.
    always_comb begin
        above_mask_s = {N_EP_IN{1'b0}};
        for (int i = 0; i < N_EP_IN; i++) begin
            above_mask_s[i] = (i > int'(last_q));
        end
        req_above_s = i_inEp_req & above_mask_s;
        if (req_above_s != {N_EP_IN{1'b0}}) begin
            pick_idx_s = lowest_set(req_above_s);
        end else begin
            pick_idx_s = lowest_set(i_inEp_req);
        end
    end

    // Last-winner pointer; resets to the top index so the first scan starts at 0.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            last_q <= IDX_W'(N_EP_IN - 1);
        end else begin
            last_q <= last_d;
        end
    end
`else
    // Winner: fixed priority, lowest index first.
    always_comb begin
        pick_idx_s = lowest_set(i_inEp_req);
    end
`endif

    assign owner_req_s = |(i_inEp_req & grant_q);
    assign expiry_s    = WDOG_EN && (cnt_q == CNT_LAST);
    assign cnt_inc_s   = (cnt_q == CNT_MAX) ? cnt_q : (cnt_q + {{(CNT_W-1){1'b0}}, 1'b1});

    // Next-state and next-output logic; done outranks req-drop, which outranks watchdog expiry.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        granted_d = granted_q;
        idx_d     = idx_q;
        timeout_d = 1'b0;
        cnt_d     = cnt_q;
`ifdef USB_EP_IN_ARB_ROUNDROBIN_EN
        last_d    = last_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (i_inEp_req != {N_EP_IN{1'b0}}) begin
                    state_d   = ST_GRANTED;
                    grant_d   = to_onehot(pick_idx_s);
                    granted_d = 1'b1;
                    idx_d     = pick_idx_s;
                    cnt_d     = {CNT_W{1'b0}};
`ifdef USB_EP_IN_ARB_ROUNDROBIN_EN
                    last_d    = pick_idx_s;
`endif
                end else begin
                    grant_d   = {N_EP_IN{1'b0}};
                    granted_d = 1'b0;
                    idx_d     = {IDX_W{1'b0}};
                    cnt_d     = {CNT_W{1'b0}};
                end
            end
            ST_GRANTED: begin
                if (i_txn_done || !owner_req_s) begin
                    state_d   = ST_IDLE;
                    grant_d   = {N_EP_IN{1'b0}};
                    granted_d = 1'b0;
                    idx_d     = {IDX_W{1'b0}};
                    cnt_d     = {CNT_W{1'b0}};
                end else if (expiry_s) begin
                    state_d   = ST_IDLE;
                    grant_d   = {N_EP_IN{1'b0}};
                    granted_d = 1'b0;
                    idx_d     = {IDX_W{1'b0}};
                    cnt_d     = {CNT_W{1'b0}};
                    timeout_d = 1'b1;
                end else begin
                    cnt_d     = cnt_inc_s;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                grant_d   = {N_EP_IN{1'b0}};
                granted_d = 1'b0;
                idx_d     = {IDX_W{1'b0}};
                cnt_d     = {CNT_W{1'b0}};
            end
        endcase
    end

    // State, output and watchdog registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= ST_IDLE;
            grant_q   <= {N_EP_IN{1'b0}};
            granted_q <= 1'b0;
            idx_q     <= {IDX_W{1'b0}};
            timeout_q <= 1'b0;
            cnt_q     <= {CNT_W{1'b0}};
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            granted_q <= granted_d;
            idx_q     <= idx_d;
            timeout_q <= timeout_d;
            cnt_q     <= cnt_d;
        end
    end

    assign o_inEp_grant   = grant_q;
    assign o_inEp_granted = granted_q;
    assign o_inEp_idx     = idx_q;
    assign o_timeout      = timeout_q;

endmodule

// File: tb/tb_usb_ep_in_arbiter.sv
// Directed bench for usb_ep_in_arbiter: cycle-level reference model plus hand-computed expectations.
module tb_usb_ep_in_arbiter;

    localparam int N = 4;
    localparam int T = 8;

    logic       clk   = 1'b0;
    logic       rst   = 1'b1;
    logic [3:0] req   = 4'b0000;
    logic [3:0] req2  = 4'b0000;
    logic       done  = 1'b0;
    logic       done2 = 1'b0;

    logic [3:0] dut_grant;
    logic       dut_granted;
    logic [1:0] dut_idx;
    logic       dut_timeout;
    logic [3:0] dut2_grant;
    logic       dut2_granted;
    logic [1:0] dut2_idx;
    logic       dut2_timeout;

    int errors = 0;
    int checks = 0;

    usb_ep_in_arbiter #(.N_EP_IN(N), .TIMEOUT_CYCLES(T)) dut (
        .i_clk(clk), .i_rst(rst), .i_inEp_req(req),
        .o_inEp_grant(dut_grant), .o_inEp_granted(dut_granted), .o_inEp_idx(dut_idx),
        .i_txn_done(done), .o_timeout(dut_timeout)
    );

    usb_ep_in_arbiter #(.N_EP_IN(N), .TIMEOUT_CYCLES(0)) dut2 (
        .i_clk(clk), .i_rst(rst), .i_inEp_req(req2),
        .o_inEp_grant(dut2_grant), .o_inEp_granted(dut2_granted), .o_inEp_idx(dut2_idx),
        .i_txn_done(done2), .o_timeout(dut2_timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // ---------------- reference model ----------------
    int cyc    = 0;
    bit m_busy = 1'b0;
    int m_idx  = 0;
    int m_gcyc = 0;
    bit m_to   = 1'b0;

`ifdef USB_EP_IN_ARB_ROUNDROBIN_EN
    int m_last = N - 1;
    function automatic int pick(input logic [3:0] r, input int last);
        int res;
        int c;
        res = -1;
        for (int k = 1; k <= N; k++) begin
            c = (last + k) % N;
            if (res < 0 && r[c]) res = c;
        end
        return res;
    endfunction
`else
    function automatic int pick(input logic [3:0] r);
        int res;
        res = -1;
        for (int c = 0; c < N; c++) begin
            if (res < 0 && r[c]) res = c;
        end
        return res;
    endfunction
`endif

    always @(posedge clk) cyc <= cyc + 1;

    // Model: grant taken at edge g is held until done, owner req drop, or edge g+T.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy <= 1'b0;
            m_idx  <= 0;
            m_to   <= 1'b0;
`ifdef USB_EP_IN_ARB_ROUNDROBIN_EN
            m_last <= N - 1;
`endif
        end else begin
            m_to <= 1'b0;
            if (!m_busy) begin
                if (req != 4'b0000) begin
                    m_busy <= 1'b1;
                    m_gcyc <= cyc;
`ifdef USB_EP_IN_ARB_ROUNDROBIN_EN
                    m_idx  <= pick(req, m_last);
                    m_last <= pick(req, m_last);
`else
                    m_idx  <= pick(req);
`endif
                end
            end else if (done) begin
                m_busy <= 1'b0;
            end else if (!req[m_idx]) begin
                m_busy <= 1'b0;
            end else if (cyc - m_gcyc == T) begin
                m_busy <= 1'b0;
                m_to   <= 1'b1;
            end
        end
    end

    // Compare process: every falling edge, DUT outputs against the model.
    initial begin
        logic [3:0] e_grant;
        logic [1:0] e_idx;
        forever begin
            @(negedge clk);
            e_grant = m_busy ? (4'b0001 << m_idx) : 4'b0000;
            e_idx   = m_busy ? 2'(m_idx) : 2'd0;
            chk("model_grant",   dut_grant,   e_grant);
            chk("model_idx",     dut_idx,     e_idx);
            chk("model_granted", dut_granted, m_busy);
            chk("model_timeout", dut_timeout, m_to);
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_time_limit: got running expected finished");
        $fatal(1, "time limit");
    end

    // ---------------- directed stimulus ----------------
    initial begin
        int n;
        int to_seen;
        int low_seen;
        logic [1:0] exp_seq [4];

        tick(2);
        chk("reset_grant",   dut_grant,   4'b0000);
        chk("reset_idx",     dut_idx,     2'd0);
        chk("reset_granted", dut_granted, 1'b0);
        chk("reset_timeout", dut_timeout, 1'b0);
        rst = 1'b0;
        tick(2);

        // single request, then done
        req = 4'b0100;
        tick(1);
        chk("t1_grant",   dut_grant,   4'b0100);
        chk("t1_idx",     dut_idx,     2'd2);
        chk("t1_granted", dut_granted, 1'b1);
        tick(3);
        done = 1'b1;
        tick(1);
        done = 1'b0;
        req  = 4'b0000;
        chk("t1_release", dut_grant, 4'b0000);
        tick(2);

        // two requesters held, done every 4 cycles
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
`ifdef USB_EP_IN_ARB_ROUNDROBIN_EN
        exp_seq[0] = 2'd1; exp_seq[1] = 2'd3; exp_seq[2] = 2'd1; exp_seq[3] = 2'd3;
`else
        exp_seq[0] = 2'd1; exp_seq[1] = 2'd1; exp_seq[2] = 2'd1; exp_seq[3] = 2'd1;
`endif
        req = 4'b1010;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            while (!dut_granted && n < 5) begin
                tick(1);
                n++;
            end
            chk("t2_grant_seen", dut_granted, 1'b1);
            chk("t2_idx_seq",    dut_idx,     exp_seq[k]);
            tick(2);
            done = 1'b1;
            tick(1);
            done = 1'b0;
            chk("t2_gap", dut_granted, 1'b0);
        end
        req = 4'b0000;
        tick(2);

        // watchdog expiry
        req = 4'b0001;
        tick(1);
        n = 0;
        while (dut_granted && n < 20) begin
            n++;
            tick(1);
        end
        chk("t3_hold_cycles", n,           8);
        chk("t3_timeout",     dut_timeout, 1'b1);
        chk("t3_revoked",     dut_grant,   4'b0000);
        req = 4'b0000;
        tick(1);
        chk("t3_pulse_width", dut_timeout, 1'b0);
        tick(2);

        // done on the expiry edge wins over the watchdog
        req = 4'b0001;
        tick(8);
        done = 1'b1;
        tick(1);
        chk("t4_released", dut_granted, 1'b0);
        chk("t4_no_pulse", dut_timeout, 1'b0);
        done = 1'b0;
        req  = 4'b0000;
        tick(1);
        chk("t4_no_pulse_late", dut_timeout, 1'b0);
        tick(2);

        // owner drops req while another is pending
        req = 4'b0100;
        tick(1);
        chk("t5_idx2", dut_idx, 2'd2);
        req = 4'b0101;
        tick(1);
        chk("t5_no_preempt", dut_grant, 4'b0100);
        req = 4'b0001;
        tick(1);
        chk("t5_drop_release", dut_grant,   4'b0000);
        chk("t5_drop_no_to",   dut_timeout, 1'b0);
        tick(1);
        chk("t5_next_grant", dut_grant, 4'b0001);
        chk("t5_next_idx",   dut_idx,   2'd0);
        req = 4'b0000;
        tick(2);

        // asynchronous reset mid-transaction
        req = 4'b1000;
        tick(1);
        chk("t6_idx3", dut_idx, 2'd3);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_async_grant",   dut_grant,   4'b0000);
        chk("t6_async_idx",     dut_idx,     2'd0);
        chk("t6_async_granted", dut_granted, 1'b0);
        chk("t6_async_timeout", dut_timeout, 1'b0);
        tick(1);
        rst = 1'b0;
        chk("t6_still_idle", dut_granted, 1'b0);
        tick(1);
        chk("t6_regrant", dut_grant, 4'b1000);
        req = 4'b0000;
        tick(2);

        // watchdog disabled: long hold without done
        req2 = 4'b0010;
        tick(1);
        to_seen  = 0;
        low_seen = 0;
        for (int i = 0; i < 5000; i++) begin
            tick(1);
            if (dut2_timeout) to_seen++;
            if (!dut2_granted || dut2_idx != 2'd1) low_seen++;
        end
        chk("t7_no_timeout", to_seen,    0);
        chk("t7_never_drop", low_seen,   0);
        chk("t7_grant_held", dut2_grant, 4'b0010);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
